// File: rtl/csr_file_pkg.sv
// Shared constants for the machine-mode CSR file: addresses, operation
// decode, mstatus bit positions and WARL write masks.
package csr_file_pkg;

  // Implemented CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // mstatus fields
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LO   = 11;
  localparam int MSTATUS_MPP_HI   = 12;

  // mcause interrupt flag
  localparam int MCAUSE_INT_BIT = 31;

  // WARL write masks
  localparam logic [31:0] MIE_WMASK   = 32'h0000_0888;
  localparam logic [31:0] MTVEC_WMASK = 32'hFFFF_FFFD;
  localparam logic [31:0] MEPC_WMASK  = 32'hFFFF_FFFC;

  // Counter slots inside the generate loop
  localparam int CNT_CYCLE   = 0;
  localparam int CNT_INSTRET = 1;
  localparam int CNT_NUM     = 2;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_RW   = 2'd1,
    OP_RS   = 2'd2,
    OP_RC   = 2'd3
  } csr_op_e;

  // Register and immediate forms behave identically once src is formed.
  function automatic csr_op_e decode_op(input logic [2:0] funct3);
    case (funct3)
      3'b001, 3'b101: return OP_RW;
      3'b010, 3'b110: return OP_RS;
      3'b011, 3'b111: return OP_RC;
      default:        return OP_NONE;
    endcase
  endfunction

  function automatic logic [31:0] apply_op(input csr_op_e op, input logic [31:0] old_value,
                                           input logic [31:0] src);
    case (op)
      OP_RW:   return src;
      OP_RS:   return old_value | src;
      OP_RC:   return old_value & ~src;
      default: return old_value;
    endcase
  endfunction

endpackage

// File: rtl/csr_file_if.sv
// Bus between write_back (master) and the CSR file (slave): CSR access,
// retire/trap/mret events, and the redirect information fed back to fetch.
interface csr_file_if;
  logic        csr_valid;
  logic [2:0]  csr_funct3;
  logic [11:0] csr_addr;
  logic [31:0] csr_src;
  logic        src_nonzero;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        retire;
  logic        trap_valid;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_tval;
  logic        mret;
  logic [31:0] trap_vector;
  logic [31:0] epc;
  logic        mie;

  modport master (
    output csr_valid, csr_funct3, csr_addr, csr_src, src_nonzero,
    output retire, trap_valid, trap_cause, trap_pc, trap_tval, mret,
    input  csr_rdata, csr_illegal, trap_vector, epc, mie
  );

  modport slave (
    input  csr_valid, csr_funct3, csr_addr, csr_src, src_nonzero,
    input  retire, trap_valid, trap_cause, trap_pc, trap_tval, mret,
    output csr_rdata, csr_illegal, trap_vector, epc, mie
  );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit event counter with independently writable halves. A write to
// either half is final for that cycle: the count does not advance and no
// carry crosses between the halves.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        lo_we,
  input  logic        hi_we,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  logic [63:0] count_reg;

  // Half-word writes take precedence over the increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (lo_we) begin
      count_reg[31:0] <= wdata;
    end else if (hi_we) begin
      count_reg[63:32] <= wdata;
    end else if (inc) begin
      count_reg <= count_reg + 64'd1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/csr_file.sv
// Machine-mode Zicsr register file. Serves CSR reads combinationally,
// commits writes on the clock edge, owns trap entry/return state and the
// cycle/instret counters, and supplies redirect targets to fetch.
module csr_file
  import csr_file_pkg::*;
#(
  parameter logic [31:0] HART_ID  = 32'd0,
  parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
  input logic      clk,
  input logic      rst_n,
  csr_file_if.slave bus
);

  logic        status_mie_reg;
  logic        status_mpie_reg;
  logic [31:0] mie_reg;
  logic [31:0] mtvec_reg;
  logic [31:0] mscratch_reg;
  logic [31:0] mepc_reg;
  logic [31:0] mcause_reg;
  logic [31:0] mtval_reg;

  logic [63:0]        count_val [CNT_NUM];
  logic [CNT_NUM-1:0] count_inc;

  csr_op_e     op;
  logic        write_attempt;
  logic        implemented;
  logic        illegal;
  logic        csr_we;
  logic [31:0] rd_value;
  logic [31:0] wdata;
  logic [31:0] tvec_base;

  assign op            = decode_op(bus.csr_funct3);
  assign write_attempt = (op == OP_RW) || (((op == OP_RS) || (op == OP_RC)) && bus.src_nonzero);

  // Read mux; also flags whether the address is implemented at all.
  always_comb begin
    rd_value    = '0;
    implemented = 1'b1;
    case (bus.csr_addr)
      CSR_MSTATUS: begin
        rd_value[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        rd_value[MSTATUS_MPIE_BIT]              = status_mpie_reg;
        rd_value[MSTATUS_MIE_BIT]               = status_mie_reg;
      end
      CSR_MISA:                    rd_value = MISA_VAL;
      CSR_MIE:                     rd_value = mie_reg;
      CSR_MTVEC:                   rd_value = mtvec_reg;
      CSR_MSCRATCH:                rd_value = mscratch_reg;
      CSR_MEPC:                    rd_value = mepc_reg;
      CSR_MCAUSE:                  rd_value = mcause_reg;
      CSR_MTVAL:                   rd_value = mtval_reg;
      CSR_MIP:                     rd_value = '0;
      CSR_MCYCLE,   CSR_CYCLE:     rd_value = count_val[CNT_CYCLE][31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:    rd_value = count_val[CNT_CYCLE][63:32];
      CSR_MINSTRET, CSR_INSTRET:   rd_value = count_val[CNT_INSTRET][31:0];
      CSR_MINSTRETH, CSR_INSTRETH: rd_value = count_val[CNT_INSTRET][63:32];
      CSR_MHARTID:                 rd_value = HART_ID;
      default:                     implemented = 1'b0;
    endcase
  end

  // Address space 11xx is read-only; any real write attempt there is illegal.
  assign illegal = bus.csr_valid &&
                   ((op == OP_NONE) || !implemented ||
                    ((bus.csr_addr[11:10] == 2'b11) && write_attempt));

  // Trap and MRET both pre-empt a CSR write issued in the same cycle.
  assign csr_we = bus.csr_valid && !illegal && write_attempt && !bus.trap_valid && !bus.mret;
  assign wdata  = apply_op(op, rd_value, bus.csr_src);

  assign bus.csr_rdata   = bus.csr_valid ? rd_value : 32'd0;
  assign bus.csr_illegal = illegal;

  // Trap target: vectored mode offsets only for interrupts.
  assign tvec_base = {mtvec_reg[31:2], 2'b00};
  always_comb begin
    bus.trap_vector = tvec_base;
    if (mtvec_reg[0] && mcause_reg[MCAUSE_INT_BIT]) begin
      bus.trap_vector = tvec_base + {mcause_reg[29:0], 2'b00};
    end
  end

  assign bus.epc = mepc_reg;
  assign bus.mie = status_mie_reg;

  // Architectural state update, trap > mret > CSR write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status_mie_reg  <= 1'b0;
      status_mpie_reg <= 1'b0;
      mie_reg         <= '0;
      mtvec_reg       <= '0;
      mscratch_reg    <= '0;
      mepc_reg        <= '0;
      mcause_reg      <= '0;
      mtval_reg       <= '0;
    end else if (bus.trap_valid) begin
      mepc_reg        <= bus.trap_pc & MEPC_WMASK;
      mcause_reg      <= bus.trap_cause;
      mtval_reg       <= bus.trap_tval;
      status_mpie_reg <= status_mie_reg;
      status_mie_reg  <= 1'b0;
    end else if (bus.mret) begin
      status_mie_reg  <= status_mpie_reg;
      status_mpie_reg <= 1'b1;
    end else if (csr_we) begin
      case (bus.csr_addr)
        CSR_MSTATUS: begin
          status_mie_reg  <= wdata[MSTATUS_MIE_BIT];
          status_mpie_reg <= wdata[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:      mie_reg      <= wdata & MIE_WMASK;
        CSR_MTVEC:    mtvec_reg    <= wdata & MTVEC_WMASK;
        CSR_MSCRATCH: mscratch_reg <= wdata;
        CSR_MEPC:     mepc_reg     <= wdata & MEPC_WMASK;
        CSR_MCAUSE:   mcause_reg   <= wdata;
        CSR_MTVAL:    mtval_reg    <= wdata;
        default:      ;
      endcase
    end
  end

  // mcycle counts every cycle out of reset; minstret counts retirements.
  assign count_inc[CNT_CYCLE]   = 1'b1;
  assign count_inc[CNT_INSTRET] = bus.retire;

  genvar gi;
  generate
    for (gi = 0; gi < CNT_NUM; gi++) begin : g_counter
      localparam logic [11:0] LO_ADDR = (gi == CNT_CYCLE) ? CSR_MCYCLE  : CSR_MINSTRET;
      localparam logic [11:0] HI_ADDR = (gi == CNT_CYCLE) ? CSR_MCYCLEH : CSR_MINSTRETH;

      csr_counter64 u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (count_inc[gi]),
        .lo_we (csr_we && (bus.csr_addr == LO_ADDR)),
        .hi_we (csr_we && (bus.csr_addr == HI_ADDR)),
        .wdata (wdata),
        .count (count_val[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: a behavioural model of the CSR rules is checked
// against the DUT every cycle, plus directed vectors with literal values.
module tb_csr_file;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csr_file_if bus();

  csr_file #(.HART_ID(32'd0), .MISA_VAL(32'h4000_0100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- behavioural model ----------------
  bit          m_ready = 1'b0;
  bit          m_mie, m_mpie;
  logic [31:0] m_mie_csr, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cycle, m_instret;

  // Returns {implemented, value}.
  function automatic logic [32:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return {1'b1, 32'h1800 + (m_mpie ? 32'h80 : 32'h0) + (m_mie ? 32'h8 : 32'h0)};
      12'h301: return {1'b1, 32'h4000_0100};
      12'h304: return {1'b1, m_mie_csr};
      12'h305: return {1'b1, m_mtvec};
      12'h340: return {1'b1, m_mscratch};
      12'h341: return {1'b1, m_mepc};
      12'h342: return {1'b1, m_mcause};
      12'h343: return {1'b1, m_mtval};
      12'h344: return {1'b1, 32'h0};
      12'hB00, 12'hC00: return {1'b1, m_cycle[31:0]};
      12'hB80, 12'hC80: return {1'b1, m_cycle[63:32]};
      12'hB02, 12'hC02: return {1'b1, m_instret[31:0]};
      12'hB82, 12'hC82: return {1'b1, m_instret[63:32]};
      12'hF14: return {1'b1, 32'h0};
      default: return {1'b0, 32'h0};
    endcase
  endfunction

  function automatic bit m_wattempt(input logic [2:0] f3, input logic nz);
    if (f3 == 3'd1 || f3 == 3'd5) return 1'b1;
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
    return nz;
  endfunction

  function automatic bit m_illegal(input logic [2:0] f3, input logic [11:0] a, input logic nz);
    logic [32:0] r;
    r = m_read(a);
    return (f3 == 3'd0) || (f3 == 3'd4) || !r[32] || ((a >= 12'hC00) && m_wattempt(f3, nz));
  endfunction

  function automatic logic [31:0] m_vector();
    logic [31:0] v;
    v = m_mtvec & 32'hFFFF_FFFC;
    if (m_mtvec[0] && m_mcause[31]) v = v + 4 * (m_mcause & 32'h7FFF_FFFF);
    return v;
  endfunction

  // Model state advance, one step per rising edge.
  always @(posedge clk) begin : model_step
    logic [63:0] cyc_n, ins_n;
    logic [32:0] r;
    logic [31:0] nv;
    if (!rst_n) begin
      m_mie = 0; m_mpie = 0;
      m_mie_csr = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
      m_cycle = 0; m_instret = 0;
      m_ready = 1'b1;
    end else if (m_ready) begin
      cyc_n = m_cycle + 64'd1;
      ins_n = m_instret + (bus.retire ? 64'd1 : 64'd0);
      if (bus.trap_valid) begin
        m_mepc = bus.trap_pc & ~32'd3;
        m_mcause = bus.trap_cause;
        m_mtval = bus.trap_tval;
        m_mpie = m_mie;
        m_mie = 1'b0;
      end else if (bus.mret) begin
        m_mie = m_mpie;
        m_mpie = 1'b1;
      end else if (bus.csr_valid && !m_illegal(bus.csr_funct3, bus.csr_addr, bus.src_nonzero)
                   && m_wattempt(bus.csr_funct3, bus.src_nonzero)) begin
        r = m_read(bus.csr_addr);
        case (bus.csr_funct3[1:0])
          2'b01:   nv = bus.csr_src;
          2'b10:   nv = r[31:0] | bus.csr_src;
          default: nv = r[31:0] & ~bus.csr_src;
        endcase
        case (bus.csr_addr)
          12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'h304: m_mie_csr = nv & 32'h888;
          12'h305: m_mtvec = nv & ~32'd2;
          12'h340: m_mscratch = nv;
          12'h341: m_mepc = nv & ~32'd3;
          12'h342: m_mcause = nv;
          12'h343: m_mtval = nv;
          12'hB00: cyc_n = {m_cycle[63:32], nv};
          12'hB80: cyc_n = {nv, m_cycle[31:0]};
          12'hB02: ins_n = {m_instret[63:32], nv};
          12'hB82: ins_n = {nv, m_instret[31:0]};
          default: ;
        endcase
      end
      m_cycle = cyc_n;
      m_instret = ins_n;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model on the falling edge.
  always @(negedge clk) begin : compare
    logic [32:0] r;
    if (m_ready && rst_n) begin
      r = m_read(bus.csr_addr);
      chk("model_rdata", bus.csr_rdata, bus.csr_valid ? r[31:0] : 32'd0);
      chk("model_illegal", {31'd0, bus.csr_illegal},
          {31'd0, bus.csr_valid && m_illegal(bus.csr_funct3, bus.csr_addr, bus.src_nonzero)});
      chk("model_vector", bus.trap_vector, m_vector());
      chk("model_epc", bus.epc, m_mepc);
      chk("model_mie", {31'd0, bus.mie}, {31'd0, m_mie});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    bus.csr_valid = 0; bus.csr_funct3 = 3'd0; bus.csr_addr = 12'd0; bus.csr_src = 0;
    bus.src_nonzero = 0; bus.retire = 0; bus.trap_valid = 0; bus.trap_cause = 0;
    bus.trap_pc = 0; bus.trap_tval = 0; bus.mret = 0;
  endtask

  task automatic csr(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] src,
                     input logic nz);
    bus.csr_valid = 1; bus.csr_funct3 = f3; bus.csr_addr = a;
    bus.csr_src = src; bus.src_nonzero = nz;
    #1;
  endtask

  task automatic rd(input logic [11:0] a);
    csr(3'b010, a, 32'd0, 1'b0);
  endtask

  initial begin
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    // Reset state and first counter values
    rd(12'hB00);  chk("mcycle_first", bus.csr_rdata, 32'h0);
                  chk("mcycle_legal", {31'd0, bus.csr_illegal}, 32'd0);  tick();
    rd(12'hB00);  chk("mcycle_second", bus.csr_rdata, 32'h1);            tick();
    rd(12'h300);  chk("mstatus_reset", bus.csr_rdata, 32'h0000_1800);
                  chk("mie_reset", {31'd0, bus.mie}, 32'd0);             tick();
    rd(12'h305);  chk("mtvec_reset", bus.csr_rdata, 32'h0);               tick();
    // mscratch RW/RS/RC
    csr(3'b001, 12'h340, 32'hDEAD_BEEF, 1); chk("rw_old", bus.csr_rdata, 32'h0); tick();
    csr(3'b010, 12'h340, 32'h0000_000F, 1); chk("rs_old", bus.csr_rdata, 32'hDEAD_BEEF); tick();
    csr(3'b011, 12'h340, 32'h0000_000F, 1); chk("rc_old", bus.csr_rdata, 32'hDEAD_BEEF); tick();
    rd(12'h340);  chk("rc_result", bus.csr_rdata, 32'hDEAD_BEE0);        tick();
    // Read-only and no-write cases
    rd(12'hB00);  chk("rs_nz0_legal", {31'd0, bus.csr_illegal}, 32'd0);  tick();
    csr(3'b001, 12'hC00, 32'h5, 1); chk("rw_c00_illegal", {31'd0, bus.csr_illegal}, 32'd1); tick();
    // Counter halves: no carry on write, then carry on increment
    csr(3'b001, 12'hB00, 32'hFFFF_FFFF, 1); tick();
    csr(3'b001, 12'hB80, 32'h0, 1);         tick();
    tick();
    tick();
    rd(12'hB00);  chk("mcycle_lo_wrap", bus.csr_rdata, 32'h1);           tick();
    rd(12'hB80);  chk("mcycle_hi_wrap", bus.csr_rdata, 32'h1);           tick();
    // Trap entry with concurrent mscratch write, then MRET
    csr(3'b001, 12'h305, 32'h0000_0101, 1); tick();
    csr(3'b010, 12'h300, 32'h8, 1); chk("mstatus_pre", bus.csr_rdata, 32'h1800); tick();
    csr(3'b001, 12'h340, 32'h1234, 1);
    bus.trap_valid = 1; bus.trap_cause = 32'h8000_000B; bus.trap_pc = 32'h1002; bus.trap_tval = 32'h77;
    #1;
    chk("mie_before_trap", {31'd0, bus.mie}, 32'd1);
    chk("trap_cycle_rdata", bus.csr_rdata, 32'hDEAD_BEE0);               tick();
    rd(12'h300);  chk("mstatus_trap", bus.csr_rdata, 32'h0000_1880);
                  chk("mie_after_trap", {31'd0, bus.mie}, 32'd0);
                  chk("epc_after_trap", bus.epc, 32'h0000_1000);
                  chk("vector_after_trap", bus.trap_vector, 32'h0000_012C); tick();
    rd(12'h340);  chk("mscratch_kept", bus.csr_rdata, 32'hDEAD_BEE0);    tick();
    rd(12'h342);  chk("mcause_trap", bus.csr_rdata, 32'h8000_000B);      tick();
    bus.mret = 1;                                                         tick();
    rd(12'h300);  chk("mstatus_mret", bus.csr_rdata, 32'h0000_1888);
                  chk("mie_after_mret", {31'd0, bus.mie}, 32'd1);        tick();
    // WARL masks
    csr(3'b001, 12'h341, 32'h1237, 1);       tick();
    rd(12'h341);  chk("mepc_warl", bus.csr_rdata, 32'h1234);             tick();
    csr(3'b001, 12'h304, 32'hFFFF_FFFF, 1);  tick();
    rd(12'h304);  chk("mie_warl", bus.csr_rdata, 32'h888);               tick();
    csr(3'b001, 12'h305, 32'hFFFF_FFFF, 1);  tick();
    rd(12'h305);  chk("mtvec_warl", bus.csr_rdata, 32'hFFFF_FFFD);       tick();
    csr(3'b001, 12'h301, 32'h0, 1); chk("misa_legal", {31'd0, bus.csr_illegal}, 32'd0); tick();
    rd(12'h301);  chk("misa_kept", bus.csr_rdata, 32'h4000_0100);        tick();
    rd(12'hF14);  chk("mhartid", bus.csr_rdata, 32'h0);                  tick();
    csr(3'b000, 12'h340, 32'h1, 1); chk("funct3_000", {31'd0, bus.csr_illegal}, 32'd1); tick();
    csr(3'b100, 12'h340, 32'h1, 1); chk("funct3_100", {31'd0, bus.csr_illegal}, 32'd1); tick();
    rd(12'h7C0);  chk("unimpl_addr", {31'd0, bus.csr_illegal}, 32'd1);   tick();
    csr(3'b001, 12'h344, 32'hFFFF, 1); chk("mip_write_legal", {31'd0, bus.csr_illegal}, 32'd0); tick();
    rd(12'h344);  chk("mip_zero", bus.csr_rdata, 32'h0);                 tick();
    // Retirement counting
    bus.retire = 1; tick();
    bus.retire = 1; tick();
    bus.retire = 1; tick();
    rd(12'hB02);  chk("minstret", bus.csr_rdata, 32'h3);                 tick();
    rd(12'hC02);  chk("instret_ro_read", bus.csr_rdata, 32'h3);          tick();
    // MRET blocks a same-cycle CSR write
    csr(3'b001, 12'h340, 32'h0, 1); bus.mret = 1;                         tick();
    rd(12'h340);  chk("mret_blocks_write", bus.csr_rdata, 32'hDEAD_BEE0); tick();
    // Reset mid-operation beats writes and trap
    rst_n = 1'b0;
    csr(3'b001, 12'h340, 32'h55, 1);
    bus.trap_valid = 1; bus.trap_pc = 32'h44;                             tick();
    rst_n = 1'b1;
    rd(12'h340);  chk("reset_mscratch", bus.csr_rdata, 32'h0);
                  chk("reset_epc", bus.epc, 32'h0);                       tick();
    rd(12'hB00);  chk("reset_mcycle", bus.csr_rdata, 32'h1);             tick();
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
